// File: rtl/bht_predictor.sv
// Branch history table: 2^INDEX_BITS 2-bit saturating counters, combinational lookup and a saturating mispredict count.
// Optional gshare indexing (global history XOR PC) is enabled by defining BHT_GSHARE_EN.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module bht_predictor #(
  parameter int unsigned INDEX_BITS = 3,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic [`PC_WIDTH-1:0]  F_PC_i,
  output logic                  F_train_predict_o,
  output logic [INDEX_BITS-1:0] F_bht_index_o,
  input  logic                  E_update_valid_i,
  input  logic [INDEX_BITS-1:0] E_update_index_i,
  input  logic                  E_update_taken_i,
  input  logic                  E_mispredict_i,
  output logic [CNT_WIDTH-1:0]  mispredict_cnt_o
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            r_table [ENTRIES];
  logic [CNT_WIDTH-1:0]  r_miss_cnt;

  logic [INDEX_BITS-1:0] w_pc_index;
  logic [INDEX_BITS-1:0] w_lookup_index;
  logic [1:0]            w_cur_ctr;
  logic [1:0]            w_next_ctr;
  logic                  w_miss_sat;
  logic                  w_unused_pc;

  assign w_pc_index  = F_PC_i[INDEX_BITS+1:2];
  // Byte-offset and upper PC bits do not participate in indexing.
  assign w_unused_pc = ^{F_PC_i[`PC_WIDTH-1:INDEX_BITS+2], F_PC_i[1:0]};

`ifdef BHT_GSHARE_EN
  logic [INDEX_BITS-1:0] r_ghr;

  assign w_lookup_index = w_pc_index ^ r_ghr;

  // History advances only on resolved branches, never speculatively.
  generate
    if (INDEX_BITS == 1) begin : g_ghr_1
      always_ff @(posedge clk_i) begin
        if (rst) begin
          r_ghr <= '0;
        end else if (E_update_valid_i) begin
          r_ghr <= E_update_taken_i;
        end
      end
    end else begin : g_ghr_n
      always_ff @(posedge clk_i) begin
        if (rst) begin
          r_ghr <= '0;
        end else if (E_update_valid_i) begin
          r_ghr <= {r_ghr[INDEX_BITS-2:0], E_update_taken_i};
        end
      end
    end
  endgenerate
`else
  assign w_lookup_index = w_pc_index;
`endif

  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  assign F_bht_index_o     = w_lookup_index;
  assign F_train_predict_o = r_table[w_lookup_index][1];

  assign w_cur_ctr = r_table[E_update_index_i];

  always_comb begin
    w_next_ctr = w_cur_ctr;
    if (E_update_taken_i) begin
      if (w_cur_ctr != 2'b11) begin
        w_next_ctr = w_cur_ctr + 2'b01;
      end
    end else begin
      if (w_cur_ctr != 2'b00) begin
        w_next_ctr = w_cur_ctr - 2'b01;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_table[i] <= 2'b01;
      end
    end else if (E_update_valid_i) begin
      r_table[E_update_index_i] <= w_next_ctr;
    end
  end

  assign w_miss_sat = &r_miss_cnt;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_miss_cnt <= '0;
    end else if (E_update_valid_i && E_mispredict_i && !w_miss_sat) begin
      r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  assign mispredict_cnt_o = r_miss_cnt;

endmodule

// File: doc/bht_predictor.md
BHT_PREDICTOR -- requirements
Module: bht_predictor

Interface
REQ-001 Parameter INDEX_BITS, default 3, log2 of the table entry count (8 entries).
REQ-002 Parameter CNT_WIDTH, default 16, width of the mispredict statistics counter.
REQ-003 Port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port F_PC_i  input  `PC_WIDTH  current fetch PC.
REQ-006 Port F_train_predict_o  output  1  taken prediction for F_PC_i; drives the next-PC stage's predict input.
REQ-007 Port F_bht_index_o  output  INDEX_BITS  table index used for this lookup; the pipeline carries it to execute.
REQ-008 Port E_update_valid_i  input  1  a resolved conditional branch is reported this cycle.
REQ-009 Port E_update_index_i  input  INDEX_BITS  index that branch was predicted with.
REQ-010 Port E_update_taken_i  input  1  actual branch outcome.
REQ-011 Port E_mispredict_i  input  1  the reported branch was mispredicted; qualified by E_update_valid_i.
REQ-012 Port mispredict_cnt_o  output  CNT_WIDTH  saturating count of mispredicts.

Function
REQ-013 The table SHALL hold 2^INDEX_BITS 2-bit saturating counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-014 Lookup SHALL be combinational, with zero-cycle latency: F_bht_index_o = F_PC_i[INDEX_BITS+1:2] (XOR-folded per REQ-027); F_train_predict_o = MSB of the addressed counter.
REQ-015 On a rising edge with E_update_valid_i=1 and taken=1, counter[E_update_index_i] SHALL increment, saturating at 11.
REQ-016 On a rising edge with E_update_valid_i=1 and taken=0, the counter SHALL decrement, saturating at 00.
REQ-017 With E_update_valid_i=0, no counter and no history SHALL change, and E_mispredict_i SHALL be ignored.
REQ-018 Lookup and update of the same index in one cycle: the lookup SHALL return the pre-update value; the new value is visible from the next cycle (no bypass).
REQ-019 Only one update per cycle; entries other than E_update_index_i SHALL be unchanged.
REQ-020 On a rising edge with E_update_valid_i=1 and E_mispredict_i=1, mispredict_cnt_o SHALL increment, holding at all-ones (no wrap).
REQ-021 The block has no stall input; prediction follows F_PC_i every cycle.

Reset
REQ-022 When rst=1 at a rising edge, all counters SHALL become 01, history SHALL become 0, and mispredict_cnt_o SHALL become 0.
REQ-023 Reset SHALL take priority over a simultaneous update; that update is lost.
REQ-024 After reset, F_train_predict_o = 0 for every PC until training occurs.
REQ-025 Reset asserted mid-training SHALL return all state to the REQ-022 values at that edge, regardless of prior contents.

Configuration
REQ-026 Macro BHT_GSHARE_EN SHALL select gshare indexing.
REQ-027 With BHT_GSHARE_EN defined:
- An INDEX_BITS-wide global history register (GHR) SHALL exist.
- F_bht_index_o = F_PC_i[INDEX_BITS+1:2] XOR GHR.
- On each valid update, GHR <= {GHR[INDEX_BITS-2:0], E_update_taken_i}; history is non-speculative and advances only at resolve.
REQ-028 Without BHT_GSHARE_EN, no GHR SHALL exist, and the index is the plain PC slice.

Verification (INDEX_BITS=3, CNT_WIDTH=16)
REQ-029 Reset, sweep F_PC_i 0x00..0x1C -> F_train_predict_o=0 and F_bht_index_o=0..7 (gshare off).
REQ-030 Two taken updates to index 5, then F_PC_i=0x14 -> predict=1; two further taken updates, then one not-taken -> predict stays 1 (11->10).
REQ-031 Three not-taken updates to index 2 from reset -> counter 00, predict=0; one taken update -> 01, predict still 0.
REQ-032 F_PC_i=0x0C with a taken update to index 3 in the same cycle -> predict=0 that cycle, predict=1 the next cycle (counter 10).
REQ-033 Hold E_update_valid_i=1 and E_mispredict_i=1 for 65537 cycles -> mispredict_cnt_o=0xFFFF; assert rst with a concurrent update -> counter 0, table all 01.
REQ-034 BHT_GSHARE_EN defined: taken updates T,T,NT -> GHR=110; F_PC_i=0x04 -> F_bht_index_o=111.
